// File: rtl/instruction_decoder_if.sv
// Bundles the instruction word and all decoded outputs of the decode stage.
//   slave  : the decoder side (takes the instruction, drives decode results)
//   master : the fetch/execute side (drives the instruction, reads results)
// Signals:
//   w_instr_32           instruction word from the instruction register
//   w_instr_out_32       registered debug copy of the instruction
//   w_alu_op/w_mem_op/w_branch_op/w_nop  one-hot class flags
//   w_op_type_6 .. w_branch_imm_val_26   raw field slices
interface instruction_decoder_if;
  logic [31:0] w_instr_32;
  logic [31:0] w_instr_out_32;
  logic        w_alu_op;
  logic        w_mem_op;
  logic        w_branch_op;
  logic        w_nop;
  logic [5:0]  w_op_type_6;
  logic [4:0]  w_rs_addr_5;
  logic [4:0]  w_rt_addr_5;
  logic [4:0]  w_rd_addr_5;
  logic [4:0]  w_sh_amt_5;
  logic [5:0]  w_func_6;
  logic [15:0] w_alu_imm_val_16;
  logic [25:0] w_branch_imm_val_26;

  modport slave (
    input  w_instr_32,
    output w_instr_out_32, w_alu_op, w_mem_op, w_branch_op, w_nop,
           w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
           w_sh_amt_5, w_func_6, w_alu_imm_val_16, w_branch_imm_val_26
  );

  modport master (
    output w_instr_32,
    input  w_instr_out_32, w_alu_op, w_mem_op, w_branch_op, w_nop,
           w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
           w_sh_amt_5, w_func_6, w_alu_imm_val_16, w_branch_imm_val_26
  );
endinterface

// File: rtl/instruction_decoder.sv
// MIPS-I instruction decode stage. Registers raw field slices of the incoming
// instruction and a one-hot class flag (ALU / memory / branch-jump / NOP).
// Latency is one cycle; a new instruction is accepted every cycle.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset; outputs zero except w_nop=1 (bubble)
//   dec    instruction_decoder_if.slave: w_instr_32 in, decoded outputs out
// Build option:
//   DECODER_INSTR_PASSTHRU_EN  when defined, w_instr_out_32 is a registered
//                              copy of the instruction; otherwise tied to 0.
module instruction_decoder (
  input  logic                  clock,
  input  logic                  reset,
  instruction_decoder_if.slave  dec
);

  logic [5:0] opcode;
  logic [5:0] func;
  logic       alu_c;
  logic       mem_c;
  logic       branch_c;
  logic       nop_c;

  assign opcode = dec.w_instr_32[31:26];
  assign func   = dec.w_instr_32[5:0];

  // Every flag starts at 0 so an unknown or X/Z word lands in the all-zero
  // default rather than propagating into the class flags.
  always_comb begin
    alu_c    = 1'b0;
    mem_c    = 1'b0;
    branch_c = 1'b0;
    nop_c    = 1'b0;
    if (dec.w_instr_32 == 32'h0000_0000) begin
      // The all-zero word encodes sll $0,$0,0 but is reported only as a bubble.
      nop_c = 1'b1;
    end else begin
      case (opcode)
        6'h00: begin
          case (func)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h10, 6'h11, 6'h12, 6'h13,
            6'h18, 6'h19, 6'h1A, 6'h1B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B:         alu_c    = 1'b1;
            6'h08, 6'h09:         branch_c = 1'b1;
            default:              ;
          endcase
        end
        6'h08, 6'h09, 6'h0A, 6'h0B,
        6'h0C, 6'h0D, 6'h0E, 6'h0F:      alu_c    = 1'b1;
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
        6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: mem_c  = 1'b1;
        6'h01, 6'h02, 6'h03, 6'h04,
        6'h05, 6'h06, 6'h07:             branch_c = 1'b1;
        default:                         ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dec.w_alu_op            <= 1'b0;
      dec.w_mem_op            <= 1'b0;
      dec.w_branch_op         <= 1'b0;
      dec.w_nop               <= 1'b1;
      dec.w_op_type_6         <= '0;
      dec.w_rs_addr_5         <= '0;
      dec.w_rt_addr_5         <= '0;
      dec.w_rd_addr_5         <= '0;
      dec.w_sh_amt_5          <= '0;
      dec.w_func_6            <= '0;
      dec.w_alu_imm_val_16    <= '0;
      dec.w_branch_imm_val_26 <= '0;
    end else begin
      dec.w_alu_op            <= alu_c;
      dec.w_mem_op            <= mem_c;
      dec.w_branch_op         <= branch_c;
      dec.w_nop               <= nop_c;
      dec.w_op_type_6         <= opcode;
      dec.w_rs_addr_5         <= dec.w_instr_32[25:21];
      dec.w_rt_addr_5         <= dec.w_instr_32[20:16];
      dec.w_rd_addr_5         <= dec.w_instr_32[15:11];
      dec.w_sh_amt_5          <= dec.w_instr_32[10:6];
      dec.w_func_6            <= func;
      dec.w_alu_imm_val_16    <= dec.w_instr_32[15:0];
      dec.w_branch_imm_val_26 <= dec.w_instr_32[25:0];
    end
  end

`ifdef DECODER_INSTR_PASSTHRU_EN
  always_ff @(posedge clock) begin
    if (reset) dec.w_instr_out_32 <= '0;
    else       dec.w_instr_out_32 <= dec.w_instr_32;
  end
`else
  assign dec.w_instr_out_32 = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed-vector bench for instruction_decoder with hand-computed expectations.
module tb_instruction_decoder;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  instruction_decoder_if dec_if ();

  instruction_decoder dut (
    .clock (clock),
    .reset (reset),
    .dec   (dec_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a word before the edge, sample 1 time unit after it.
  task automatic drive(input logic [31:0] instr, input logic rst);
    @(negedge clock);
    dec_if.w_instr_32 = instr;
    reset = rst;
    @(posedge clock);
    #1;
  endtask

  // flags packed as {alu, mem, branch, nop}
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'h0, dec_if.w_alu_op, dec_if.w_mem_op,
                dec_if.w_branch_op, dec_if.w_nop}, {28'h0, exp});
  endtask

  task automatic check_pass(input string tag, input logic [31:0] instr);
`ifdef DECODER_INSTR_PASSTHRU_EN
    check(tag, dec_if.w_instr_out_32, instr);
`else
    check(tag, dec_if.w_instr_out_32, 32'h0);
    if (instr == 32'hDEAD_BEEF) checks += 0;
`endif
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } vec_t;

  vec_t stream [4];

  initial begin
    errors = 0;
    checks = 0;
    dec_if.w_instr_32 = 32'h0;
    reset = 1'b1;

    // Reset held 2 cycles with an all-ones input
    drive(32'hFFFF_FFFF, 1'b1);
    drive(32'hFFFF_FFFF, 1'b1);
    check_flags("rst_flags", 4'b0001);
    check("rst_op",    {26'h0, dec_if.w_op_type_6}, 32'h0);
    check("rst_rs",    {27'h0, dec_if.w_rs_addr_5}, 32'h0);
    check("rst_rt",    {27'h0, dec_if.w_rt_addr_5}, 32'h0);
    check("rst_rd",    {27'h0, dec_if.w_rd_addr_5}, 32'h0);
    check("rst_sh",    {27'h0, dec_if.w_sh_amt_5},  32'h0);
    check("rst_func",  {26'h0, dec_if.w_func_6},    32'h0);
    check("rst_imm16", {16'h0, dec_if.w_alu_imm_val_16}, 32'h0);
    check("rst_imm26", {6'h0,  dec_if.w_branch_imm_val_26}, 32'h0);
    check("rst_pass",  dec_if.w_instr_out_32, 32'h0);

    drive(32'h0000_0000, 1'b0);
    check_flags("nop_flags", 4'b0001);

    // add $8,$9,$10
    drive(32'h012A_4020, 1'b0);
    check_flags("add_flags", 4'b1000);
    check("add_op",   {26'h0, dec_if.w_op_type_6}, 32'h00);
    check("add_rs",   {27'h0, dec_if.w_rs_addr_5}, 32'd9);
    check("add_rt",   {27'h0, dec_if.w_rt_addr_5}, 32'd10);
    check("add_rd",   {27'h0, dec_if.w_rd_addr_5}, 32'd8);
    check("add_sh",   {27'h0, dec_if.w_sh_amt_5},  32'd0);
    check("add_func", {26'h0, dec_if.w_func_6},    32'h20);
    check_pass("add_pass", 32'h012A_4020);

    // addi $8,$9,-1 (no sign extension)
    drive(32'h2128_FFFF, 1'b0);
    check_flags("addi_flags", 4'b1000);
    check("addi_imm16", {16'h0, dec_if.w_alu_imm_val_16}, 32'h0000_FFFF);

    // lw $8,4($9)
    drive(32'h8D28_0004, 1'b0);
    check_flags("lw_flags", 4'b0100);
    check("lw_op",    {26'h0, dec_if.w_op_type_6}, 32'h23);
    check("lw_imm16", {16'h0, dec_if.w_alu_imm_val_16}, 32'h0004);

    // beq
    drive(32'h1109_FFFE, 1'b0);
    check_flags("beq_flags", 4'b0010);
    check("beq_imm16", {16'h0, dec_if.w_alu_imm_val_16}, 32'h0000_FFFE);

    // jal
    drive(32'h0C00_0010, 1'b0);
    check_flags("jal_flags", 4'b0010);
    check("jal_imm26", {6'h0, dec_if.w_branch_imm_val_26}, 32'h10);

    // jr $9: branch, not ALU
    drive(32'h0120_0008, 1'b0);
    check_flags("jr_flags", 4'b0010);

    // bal (REGIMM)
    drive(32'h0411_0003, 1'b0);
    check_flags("regimm_flags", 4'b0010);

    // sll $8,$8,2: nonzero sll is ALU
    drive(32'h0008_4080, 1'b0);
    check_flags("sll_flags", 4'b1000);
    check("sll_sh", {27'h0, dec_if.w_sh_amt_5}, 32'd2);

    // syscall: R-type with unlisted func
    drive(32'h0000_000C, 1'b0);
    check_flags("syscall_flags", 4'b0000);
    check("syscall_func", {26'h0, dec_if.w_func_6}, 32'h0C);

    // Unrecognized opcode
    drive(32'hFC00_0000, 1'b0);
    check_flags("unk_flags", 4'b0000);
    check("unk_op", {26'h0, dec_if.w_op_type_6}, 32'h3F);

    // Back-to-back stream of four
    stream[0] = '{32'hAD28_0004, 4'b0100, 6'h2B, 5'd9,  5'd8,  16'h0004};
    stream[1] = '{32'h3C01_1234, 4'b1000, 6'h0F, 5'd0,  5'd1,  16'h1234};
    stream[2] = '{32'h0800_0040, 4'b0010, 6'h02, 5'd0,  5'd0,  16'h0040};
    stream[3] = '{32'h0232_8822, 4'b1000, 6'h00, 5'd17, 5'd18, 16'h8822};
    for (int i = 0; i < 4; i++) begin
      drive(stream[i].instr, 1'b0);
      check_flags($sformatf("strm%0d_flags", i), stream[i].flags);
      check($sformatf("strm%0d_op", i),  {26'h0, dec_if.w_op_type_6}, {26'h0, stream[i].op});
      check($sformatf("strm%0d_rs", i),  {27'h0, dec_if.w_rs_addr_5}, {27'h0, stream[i].rs});
      check($sformatf("strm%0d_rt", i),  {27'h0, dec_if.w_rt_addr_5}, {27'h0, stream[i].rt});
      check($sformatf("strm%0d_imm", i), {16'h0, dec_if.w_alu_imm_val_16}, {16'h0, stream[i].imm});
      check_pass($sformatf("strm%0d_pass", i), stream[i].instr);
    end

    // Mid-stream reset drops the sampled word; next word decodes normally
    drive(32'h8D28_0004, 1'b1);
    check_flags("midrst_flags", 4'b0001);
    check("midrst_op", {26'h0, dec_if.w_op_type_6}, 32'h0);
    check("midrst_pass", dec_if.w_instr_out_32, 32'h0);
    drive(32'h2128_FFFF, 1'b0);
    check_flags("postrst_flags", 4'b1000);
    check("postrst_op", {26'h0, dec_if.w_op_type_6}, 32'h08);
    check_pass("postrst_pass", 32'h2128_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
